frame_addr_seq: RTL and testbench

Multi-buffer frame address sequencer for the VDMA read/write channels: it generates the AXI burst start address for every burst of a frame. Frames rotate through up to `NUM_FB` frame buffers spaced by a runtime stride. Bursts are counted per line, and lines per frame; line ends are realigned to the line stride. The block sits between the channel's frame/line control FSM (which raises `burst_done` / `tail_done`) and the AXI address-channel driver (which consumes `out_addr`).

---
 rtl/frame_addr_seq.sv | 163 ++++++++++++++++
 tb/tb_frame_addr_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_addr_seq.sv
// Frame address sequencer: rotates through frame buffers and produces the AXI
// burst start address for every burst, realigning line ends to the line stride.
module frame_addr_seq #(
  parameter int unsigned ASIZE          = 29,
  parameter int unsigned BURST_MAP_ADDR = 200*8*8,
  parameter int unsigned NUM_FB         = 4,
  parameter int unsigned FBW            = 2,
  parameter int unsigned BCW            = 12,
  parameter int unsigned LCW            = 12
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             new_base,
  input  logic [ASIZE-1:0] baseaddr,
  input  logic [ASIZE-1:0] frame_stride,
  input  logic [ASIZE-1:0] line_increate_addr,
  input  logic [BCW-1:0]   bursts_per_line,
  input  logic [LCW-1:0]   lines_per_frame,
  input  logic [FBW:0]     fb_num,
  input  logic             burst_done,
  input  logic             tail_done,
  output logic [ASIZE-1:0] out_addr,
  output logic [FBW-1:0]   fb_index,
  output logic [LCW-1:0]   line_cnt,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int unsigned FBNW = FBW + 1;
  localparam logic [ASIZE-1:0] BURST_INC = ASIZE'(BURST_MAP_ADDR);
  localparam logic [FBNW-1:0]  MAX_FB    = FBNW'(NUM_FB);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [ASIZE-1:0] out_addr_q, out_addr_d;
  logic [ASIZE-1:0] frame_base_q, frame_base_d;
  logic [ASIZE-1:0] line_base_q, line_base_d;
  logic [FBW-1:0]   fb_index_q, fb_index_d;
  logic [LCW-1:0]   line_cnt_q, line_cnt_d;
  logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;
  logic             first_q, first_d;
  logic             burst_d_q, tail_d_q;
  logic             burst_ev_q, burst_ev_d;
  logic             tail_ev_q, tail_ev_d;

  logic [FBNW-1:0]  eff_fb_num;
  logic [FBNW-1:0]  idx_inc;
  logic [FBW-1:0]   new_idx;
  logic [ASIZE-1:0] new_line_base;
  logic             line_end;

  // State and datapath registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_addr_q   <= '0;
      frame_base_q <= '0;
      line_base_q  <= '0;
      fb_index_q   <= '0;
      line_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      first_q      <= 1'b1;
      burst_d_q    <= 1'b0;
      tail_d_q     <= 1'b0;
      burst_ev_q   <= 1'b0;
      tail_ev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_addr_q   <= out_addr_d;
      frame_base_q <= frame_base_d;
      line_base_q  <= line_base_d;
      fb_index_q   <= fb_index_d;
      line_cnt_q   <= line_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      first_q      <= first_d;
      burst_d_q    <= burst_done;
      tail_d_q     <= tail_done;
      burst_ev_q   <= burst_ev_d;
      tail_ev_q    <= tail_ev_d;
    end
  end

  // Next-state: new_base has priority; an edge detected alongside new_base is dropped
  always_comb begin
    state_d       = state_q;
    out_addr_d    = out_addr_q;
    frame_base_d  = frame_base_q;
    line_base_d   = line_base_q;
    fb_index_d    = fb_index_q;
    line_cnt_d    = line_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    frame_done_d  = 1'b0;
    overrun_d     = 1'b0;
    first_d       = first_q;
    burst_ev_d    = burst_done & ~burst_d_q & ~new_base;
    tail_ev_d     = tail_done & ~tail_d_q & ~new_base;
    line_end      = 1'b0;
    new_line_base = line_base_q + line_increate_addr;

    if (fb_num == '0)        eff_fb_num = FBNW'(1);
    else if (fb_num > MAX_FB) eff_fb_num = MAX_FB;
    else                      eff_fb_num = fb_num;

    idx_inc = {1'b0, fb_index_q} + FBNW'(1);
    if (first_q || (idx_inc >= eff_fb_num)) new_idx = '0;
    else                                    new_idx = idx_inc[FBW-1:0];

    if (new_base) begin
      fb_index_d   = new_idx;
      frame_base_d = (new_idx == '0) ? baseaddr : (frame_base_q + frame_stride);
      line_base_d  = frame_base_d;
      out_addr_d   = frame_base_d;
      burst_cnt_d  = '0;
      line_cnt_d   = '0;
      first_d      = 1'b0;
      state_d      = ACTIVE;
    end else if (burst_ev_q || tail_ev_q) begin
      if (state_q == ACTIVE) begin
        line_end = tail_ev_q ||
                   ((bursts_per_line != '0) &&
                    (burst_cnt_q == (bursts_per_line - BCW'(1))));
        if (line_end) begin
          line_base_d = new_line_base;
          out_addr_d  = new_line_base;
          burst_cnt_d = '0;
          if ((lines_per_frame != '0) &&
              (line_cnt_q == (lines_per_frame - LCW'(1)))) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else begin
            line_cnt_d = line_cnt_q + LCW'(1);
          end
        end else begin
          out_addr_d  = out_addr_q + BURST_INC;
          burst_cnt_d = burst_cnt_q + BCW'(1);
        end
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d == ACTIVE);
  end

  assign out_addr   = out_addr_q;
  assign fb_index   = fb_index_q;
  assign line_cnt   = line_cnt_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_addr_seq.sv
// Self-checking bench for frame_addr_seq: directed scenarios plus a randomized
// run against a behavioural frame/line/burst model.
module tb_frame_addr_seq;
  localparam int unsigned ASIZE = 29;
  localparam int unsigned FBW   = 2;
  localparam int unsigned BCW   = 12;
  localparam int unsigned LCW   = 12;
  localparam logic [ASIZE-1:0] BINC = 29'h3200;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             new_base = 1'b0;
  logic [ASIZE-1:0] baseaddr = '0, frame_stride = '0, line_increate_addr = '0;
  logic [BCW-1:0]   bursts_per_line = '0;
  logic [LCW-1:0]   lines_per_frame = '0;
  logic [FBW:0]     fb_num = 3'd1;
  logic             burst_done = 1'b0, tail_done = 1'b0;
  logic [ASIZE-1:0] out_addr;
  logic [FBW-1:0]   fb_index;
  logic [LCW-1:0]   line_cnt;
  logic             busy, frame_done, overrun;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [ASIZE-1:0] m_fbase, m_lbase, m_addr;
  int m_idx, m_line, m_bcnt, m_state;  // m_state: 0 idle, 1 active, 2 done
  bit m_first, m_fd, m_ov;

  frame_addr_seq dut (
    .clock(clock), .rst_n(rst_n), .new_base(new_base), .baseaddr(baseaddr),
    .frame_stride(frame_stride), .line_increate_addr(line_increate_addr),
    .bursts_per_line(bursts_per_line), .lines_per_frame(lines_per_frame),
    .fb_num(fb_num), .burst_done(burst_done), .tail_done(tail_done),
    .out_addr(out_addr), .fb_index(fb_index), .line_cnt(line_cnt),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_new_base();
    new_base = 1'b1;
    tick();
    new_base = 1'b0;
  endtask

  // One edge (high one cycle, then low); result is visible after the second edge.
  task automatic send_event(input bit b, input bit t);
    burst_done = b;
    tail_done  = t;
    tick();
    burst_done = 1'b0;
    tail_done  = 1'b0;
    tick();
  endtask

  task automatic m_reset();
    m_fbase = '0; m_lbase = '0; m_addr = '0;
    m_idx = 0; m_line = 0; m_bcnt = 0; m_state = 0; m_first = 1;
    m_fd = 0; m_ov = 0;
  endtask

  task automatic m_new_base();
    int eff;
    eff = (fb_num == 0) ? 1 : ((int'(fb_num) > 4) ? 4 : int'(fb_num));
    if (m_first || (m_idx + 1 >= eff)) m_idx = 0;
    else m_idx = m_idx + 1;
    m_first = 0;
    m_fbase = (m_idx == 0) ? baseaddr : m_fbase + frame_stride;
    m_lbase = m_fbase;
    m_addr  = m_fbase;
    m_line = 0; m_bcnt = 0; m_state = 1;
    m_fd = 0; m_ov = 0;
  endtask

  task automatic m_event(input bit b, input bit t);
    m_fd = 0; m_ov = 0;
    if (m_state != 1) begin
      m_ov = 1;
    end else if (t || (bursts_per_line != 0 && m_bcnt + 1 == int'(bursts_per_line))) begin
      m_lbase = m_lbase + line_increate_addr;
      m_addr  = m_lbase;
      m_bcnt  = 0;
      if (lines_per_frame != 0 && m_line + 1 == int'(lines_per_frame)) begin
        m_state = 2;
        m_fd = 1;
      end else begin
        m_line = m_line + 1;
      end
    end else if (b) begin
      m_addr = m_addr + BINC;
      m_bcnt = m_bcnt + 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_addr !== '0 || fb_index !== '0 || line_cnt !== '0 ||
        busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL reset: addr=%h idx=%0d line=%0d busy=%b fd=%b ov=%b, required all 0",
               out_addr, fb_index, line_cnt, busy, frame_done, overrun);
      failures++;
    end
  endtask

  task automatic test_first_frame();
    baseaddr = 29'h1000; fb_num = 3'd1;
    pulse_new_base();
    checks++;
    if (out_addr !== 29'h1000 || fb_index !== 2'd0 || busy !== 1'b1) begin
      $display("FAIL first_frame: addr=%h idx=%0d busy=%b, required 1000/0/1",
               out_addr, fb_index, busy);
      failures++;
    end
  endtask

  task automatic test_bursts();
    logic [ASIZE-1:0] exp_a [3];
    exp_a[0] = 29'h4200; exp_a[1] = 29'h7400; exp_a[2] = 29'h11000;
    bursts_per_line = 12'd3; line_increate_addr = 29'h10000; lines_per_frame = '0;
    for (int i = 0; i < 3; i++) begin
      send_event(1'b1, 1'b0);
      checks++;
      if (out_addr !== exp_a[i]) begin
        $display("FAIL bursts[%0d]: addr=%h, required %h", i, out_addr, exp_a[i]);
        failures++;
      end
    end
    checks++;
    if (line_cnt !== 12'd1) begin
      $display("FAIL bursts_line_cnt: line=%0d, required 1", line_cnt);
      failures++;
    end
  endtask

  task automatic test_tail();
    bursts_per_line = '0;
    pulse_new_base();
    send_event(1'b1, 1'b0);
    checks++;
    if (out_addr !== 29'h4200) begin
      $display("FAIL tail_burst: addr=%h, required 4200", out_addr);
      failures++;
    end
    send_event(1'b0, 1'b1);
    checks++;
    if (out_addr !== 29'h11000 || line_cnt !== 12'd1) begin
      $display("FAIL tail_realign: addr=%h line=%0d, required 11000/1", out_addr, line_cnt);
      failures++;
    end
    send_event(1'b1, 1'b1);
    checks++;
    if (out_addr !== 29'h21000 || line_cnt !== 12'd2) begin
      $display("FAIL tail_and_burst: addr=%h line=%0d, required 21000/2", out_addr, line_cnt);
      failures++;
    end
    // Level held high for several cycles counts once
    burst_done = 1'b1;
    repeat (4) tick();
    burst_done = 1'b0;
    tick();
    checks++;
    if (out_addr !== 29'h24200) begin
      $display("FAIL held_level: addr=%h, required 24200", out_addr);
      failures++;
    end
  endtask

  task automatic test_frame_done();
    bursts_per_line = 12'd1; lines_per_frame = 12'd2;
    pulse_new_base();
    send_event(1'b1, 1'b0);
    checks++;
    if (out_addr !== 29'h11000 || frame_done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL fd_line1: addr=%h fd=%b busy=%b, required 11000/0/1",
               out_addr, frame_done, busy);
      failures++;
    end
    send_event(1'b1, 1'b0);
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || line_cnt !== 12'd1 || out_addr !== 29'h21000) begin
      $display("FAIL fd_pulse: fd=%b busy=%b line=%0d addr=%h, required 1/0/1/21000",
               frame_done, busy, line_cnt, out_addr);
      failures++;
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      $display("FAIL fd_one_cycle: fd=%b, required 0", frame_done);
      failures++;
    end
    send_event(1'b1, 1'b0);
    checks++;
    if (overrun !== 1'b1 || out_addr !== 29'h21000 || frame_done !== 1'b0) begin
      $display("FAIL overrun: ov=%b addr=%h fd=%b, required 1/21000/0",
               overrun, out_addr, frame_done);
      failures++;
    end
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      $display("FAIL overrun_one_cycle: ov=%b, required 0", overrun);
      failures++;
    end
  endtask

  task automatic test_fb_rotate();
    logic [ASIZE-1:0] exp_a [4];
    int exp_i [4];
    exp_a[0] = 29'h1000; exp_a[1] = 29'h101000; exp_a[2] = 29'h201000; exp_a[3] = 29'h1000;
    exp_i[0] = 0; exp_i[1] = 1; exp_i[2] = 2; exp_i[3] = 0;
    do_reset();
    baseaddr = 29'h1000; frame_stride = 29'h100000; fb_num = 3'd3; lines_per_frame = '0;
    for (int i = 0; i < 4; i++) begin
      pulse_new_base();
      checks++;
      if (out_addr !== exp_a[i] || fb_index !== FBW'(exp_i[i])) begin
        $display("FAIL fb_rotate[%0d]: addr=%h idx=%0d, required %h/%0d",
                 i, out_addr, fb_index, exp_a[i], exp_i[i]);
        failures++;
      end
    end
    fb_num = 3'd0;
    for (int i = 0; i < 2; i++) begin
      pulse_new_base();
      checks++;
      if (fb_index !== 2'd0 || out_addr !== 29'h1000) begin
        $display("FAIL fb_num0[%0d]: idx=%0d addr=%h, required 0/1000", i, fb_index, out_addr);
        failures++;
      end
    end
    fb_num = 3'd7;
    for (int i = 1; i <= 5; i++) begin
      pulse_new_base();
      checks++;
      if (fb_index !== FBW'(i % 4)) begin
        $display("FAIL fb_clamp[%0d]: idx=%0d, required %0d", i, fb_index, i % 4);
        failures++;
      end
    end
  endtask

  task automatic test_coincident();
    fb_num = 3'd1; bursts_per_line = '0;
    pulse_new_base();
    send_event(1'b1, 1'b0);
    new_base = 1'b1; burst_done = 1'b1;
    tick();
    new_base = 1'b0;
    checks++;
    if (out_addr !== 29'h1000 || busy !== 1'b1) begin
      $display("FAIL coincident_restart: addr=%h busy=%b, required 1000/1", out_addr, busy);
      failures++;
    end
    tick();
    burst_done = 1'b0;
    tick();
    checks++;
    if (out_addr !== 29'h1000 || overrun !== 1'b0) begin
      $display("FAIL coincident_drop: addr=%h ov=%b, required 1000/0", out_addr, overrun);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    send_event(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_addr !== '0 || fb_index !== '0 || line_cnt !== '0 ||
        busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL reset_mid: addr=%h idx=%0d line=%0d busy=%b fd=%b ov=%b, required all 0",
               out_addr, fb_index, line_cnt, busy, frame_done, overrun);
      failures++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_mid_after: fd=%b busy=%b, required 0/0", frame_done, busy);
      failures++;
    end
  endtask

  task automatic test_wrap();
    baseaddr = 29'h1FFF_FF00; line_increate_addr = 29'h10000;
    bursts_per_line = '0; lines_per_frame = '0; fb_num = 3'd1;
    pulse_new_base();
    send_event(1'b1, 1'b0);
    checks++;
    if (out_addr !== 29'h3100) begin
      $display("FAIL wrap_burst: addr=%h, required 3100", out_addr);
      failures++;
    end
    send_event(1'b0, 1'b1);
    checks++;
    if (out_addr !== 29'hFF00) begin
      $display("FAIL wrap_line: addr=%h, required ff00", out_addr);
      failures++;
    end
  endtask

  task automatic test_random();
    int op;
    do_reset();
    m_reset();
    for (int n = 0; n < 300; n++) begin
      op = (n == 0) ? 0 : int'($urandom_range(0, 11));
      if (op == 0) begin
        baseaddr           = ASIZE'($urandom);
        frame_stride       = ASIZE'($urandom);
        line_increate_addr = ASIZE'($urandom);
        bursts_per_line    = BCW'($urandom_range(0, 3));
        lines_per_frame    = LCW'($urandom_range(0, 3));
        fb_num             = 3'($urandom_range(0, 7));
        pulse_new_base();
        m_new_base();
      end else begin
        send_event(op <= 6, op >= 6);
        m_event(op <= 6, op >= 6);
      end
      checks++;
      if (out_addr !== m_addr || fb_index !== FBW'(m_idx) || line_cnt !== LCW'(m_line) ||
          busy !== (m_state == 1) || frame_done !== m_fd || overrun !== m_ov) begin
        $display("FAIL random[%0d] op=%0d: addr=%h idx=%0d line=%0d busy=%b fd=%b ov=%b, required %h/%0d/%0d/%b/%b/%b",
                 n, op, out_addr, fb_index, line_cnt, busy, frame_done, overrun,
                 m_addr, m_idx, m_line, m_state == 1, m_fd, m_ov);
        failures++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_bursts();
    test_tail();
    test_frame_done();
    test_fb_rotate();
    test_coincident();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
